stack_drain: RTL and testbench

Pop-side reader for the LIFO stack. It accepts a drain command of N entries and drives the stack's pop interface (pop enable, pop data, empty flag). It returns the popped items, top first, as a valid/ready output stream with a last flag. It sits between the stack and any consumer that wants packetised stack contents, and it sustains one item per cycle when the consumer never back-pressures.

---
 rtl/stack_pkg.sv | 16 +
 rtl/stream_oreg.sv | 33 +++
 rtl/stack_drain.sv | 105 ++++++++++
 tb/tb_stack_drain.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stack_pkg.sv
// Shared definitions for the LIFO stack and its pop-side drain reader.
// The length-width helper keeps the stack and its readers agreeing on field widths.
package stack_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2
  } drain_state_t;

  // Width of a field that must represent every count from 0 up to depth.
  function automatic int len_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/stream_oreg.sv
// Single-entry valid/ready output register: a load captures a beat, which is
// held stable until the consumer accepts it.
module stream_oreg #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          aresetn,
  input  logic          load,
  input  logic [DW-1:0] load_data,
  input  logic          load_last,
  input  logic          ready,
  output logic          valid,
  output logic [DW-1:0] data,
  output logic          last
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      valid <= 1'b0;
      data  <= '0;
      last  <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
      last  <= load_last;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/stack_drain.sv
// Pop-side reader for the LIFO stack: drains N entries (top first) into a
// valid/ready stream with a last flag, and reports completion with a beat count.
module stack_drain
  import stack_pkg::*;
#(
  parameter  int DPT = 4,
  parameter  int DW  = 8,
  localparam int LW  = len_w(DPT)
) (
  input  logic          clk,
  input  logic          aresetn,
  input  logic          i_cmd_valid,
  input  logic [LW-1:0] i_cmd_len,
  output logic          o_cmd_ready,
  output logic          o_pop_en,
  input  logic [DW-1:0] i_pop_data,
  input  logic          i_empty,
  output logic          o_m_valid,
  output logic [DW-1:0] o_m_data,
  output logic          o_m_last,
  input  logic          i_m_ready,
  output logic          o_stall,
  output logic          o_done,
  output logic [LW-1:0] o_done_cnt
);

  drain_state_t  state, state_nxt;
  logic [LW-1:0] rem, cnt;
  logic [LW-1:0] len_c;
  logic          cmd_fire;
  logic          beat_accept;

  assign len_c       = (i_cmd_len > LW'(DPT)) ? LW'(DPT) : i_cmd_len;
  assign cmd_fire    = i_cmd_valid && o_cmd_ready;
  assign beat_accept = o_m_valid && i_m_ready;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_nxt;
  end

  // NOTE: every combinational output gets a default first so no path
  // through the case statement can leave it unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (cmd_fire && len_c != '0) state_nxt = DRAIN;
      DRAIN:   if (o_pop_en && rem == LW'(1)) state_nxt = FLUSH;
      FLUSH:   if (beat_accept) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A pop needs stock on the stack, work left, and a free (or draining) output slot.
  always_comb begin
    o_cmd_ready = 1'b0;
    o_pop_en    = 1'b0;
    unique case (state)
      IDLE:    o_cmd_ready = 1'b1;
      DRAIN:   o_pop_en    = !i_empty && rem != '0 && (!o_m_valid || i_m_ready);
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      rem        <= '0;
      cnt        <= '0;
      o_done     <= 1'b0;
      o_done_cnt <= '0;
      o_stall    <= 1'b0;
    end else begin
      o_done  <= 1'b0;
      o_stall <= (state == DRAIN) && i_empty && rem != '0;
      if (cmd_fire) begin
        rem <= len_c;
        cnt <= '0;
        if (len_c == '0) begin
          o_done     <= 1'b1;
          o_done_cnt <= '0;
        end
      end else if (o_pop_en) begin
        rem <= rem - LW'(1);
        cnt <= cnt + LW'(1);
      end
      if (state == FLUSH && beat_accept) begin
        o_done     <= 1'b1;
        o_done_cnt <= cnt;
      end
    end
  end

  stream_oreg #(.DW(DW)) u_oreg (
    .clk       (clk),
    .aresetn   (aresetn),
    .load      (o_pop_en),
    .load_data (i_pop_data),
    .load_last (rem == LW'(1)),
    .ready     (i_m_ready),
    .valid     (o_m_valid),
    .data      (o_m_data),
    .last      (o_m_last)
  );

endmodule

// File: tb/tb_stack_drain.sv
// Bench for stack_drain: a behavioural LIFO feeds the DUT and a scoreboard
// checks every delivered beat, the hold behaviour and the completion report.
module tb_stack_drain;

  localparam int DPT = 4;
  localparam int DW  = 8;
  localparam int LW  = $clog2(DPT + 1);

  typedef struct packed {
    logic          last;
    logic [DW-1:0] data;
  } beat_t;

  logic          clk = 1'b0;
  logic          aresetn;
  logic          i_cmd_valid;
  logic [LW-1:0] i_cmd_len;
  logic          o_cmd_ready;
  logic          o_pop_en;
  logic [DW-1:0] i_pop_data;
  logic          i_empty;
  logic          o_m_valid;
  logic [DW-1:0] o_m_data;
  logic          o_m_last;
  logic          i_m_ready;
  logic          o_stall;
  logic          o_done;
  logic [LW-1:0] o_done_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  stack_drain #(.DPT(DPT), .DW(DW)) dut (
    .clk         (clk),
    .aresetn     (aresetn),
    .i_cmd_valid (i_cmd_valid),
    .i_cmd_len   (i_cmd_len),
    .o_cmd_ready (o_cmd_ready),
    .o_pop_en    (o_pop_en),
    .i_pop_data  (i_pop_data),
    .i_empty     (i_empty),
    .o_m_valid   (o_m_valid),
    .o_m_data    (o_m_data),
    .o_m_last    (o_m_last),
    .i_m_ready   (i_m_ready),
    .o_stall     (o_stall),
    .o_done      (o_done),
    .o_done_cnt  (o_done_cnt)
  );

  // Behavioural stack: combinational top/empty, push and pop on the clock edge.
  logic [DW-1:0] mem [0:DPT-1];
  int            sp = 0;
  logic          push_req = 1'b0;
  logic [DW-1:0] push_data = '0;
  logic          m_clr = 1'b0;
  int            pop_cnt = 0;
  int            pop_viol = 0;

  assign i_empty    = (sp == 0);
  assign i_pop_data = (sp == 0) ? '0 : mem[sp-1];

  always @(posedge clk) begin
    if (o_pop_en) pop_cnt++;
    if (o_pop_en && sp == 0) pop_viol++;
    if (m_clr) sp <= 0;
    else if (push_req && !o_pop_en) begin
      mem[sp] <= push_data;
      sp      <= sp + 1;
    end else if (push_req && o_pop_en) mem[sp-1] <= push_data;
    else if (o_pop_en && sp > 0) sp <= sp - 1;
  end

  // Scoreboard monitor, sampled on the falling edge.
  beat_t exp_q[$];
  logic  hold_prev = 1'b0;
  beat_t prev_beat;
  beat_t got, exp_b;

  always @(negedge clk) begin
    if (!aresetn) hold_prev = 1'b0;
    else begin
      got = {o_m_last, o_m_data};
      if (hold_prev) begin
        tests++;
        if (o_m_valid !== 1'b1 || got !== prev_beat) begin
          fails++;
          $display("FAIL hold_stable: got valid=%b last/data=%h, required valid=1 last/data=%h",
                   o_m_valid, got, prev_beat);
        end
      end
      if (o_m_valid && i_m_ready) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_beat: got last/data=%h, required no beat", got);
        end else begin
          exp_b = exp_q.pop_front();
          if (got !== exp_b) begin
            fails++;
            $display("FAIL beat: got last/data=%h, required %h", got, exp_b);
          end
        end
      end
      hold_prev = o_m_valid && !i_m_ready;
      prev_beat = got;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_item(input logic [DW-1:0] d);
    push_req  = 1'b1;
    push_data = d;
    tick();
    push_req  = 1'b0;
  endtask

  task automatic clear_stack();
    m_clr = 1'b1;
    tick();
    m_clr = 1'b0;
  endtask

  // Present a command for one cycle (DUT is idle) and queue the beats it should yield.
  task automatic issue_cmd(input int len);
    int n;
    n = (len > DPT) ? DPT : len;
    for (int k = 0; k < n && k < sp; k++)
      exp_q.push_back({(k == n - 1), mem[sp-1-k]});
    i_cmd_valid = 1'b1;
    i_cmd_len   = LW'(len);
    tick();
    i_cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cycles);
    cycles = 0;
    do begin
      tick();
      cycles++;
    end while (!o_done && cycles < budget);
    if (!o_done) begin
      tests++;
      fails++;
      $display("FAIL done_timeout: got no o_done within %0d cycles, required a pulse", budget);
    end
  endtask

  task automatic test_reset();
    aresetn     = 1'b0;
    i_cmd_valid = 1'b0;
    i_cmd_len   = '0;
    i_m_ready   = 1'b1;
    repeat (2) tick();
    tests++;
    if ({o_cmd_ready, o_m_valid, o_m_data, o_m_last, o_stall, o_done, o_done_cnt, o_pop_en}
        !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0}) begin
      fails++;
      $display("FAIL reset_values: got rdy=%b v=%b d=%h l=%b st=%b dn=%b cnt=%0d pop=%b, required 1 0 00 0 0 0 0 0",
               o_cmd_ready, o_m_valid, o_m_data, o_m_last, o_stall, o_done, o_done_cnt, o_pop_en);
    end
    aresetn = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int pc0, cyc;
    clear_stack();
    push_item(8'h11); push_item(8'h22); push_item(8'h33);
    i_m_ready = 1'b1;
    pc0 = pop_cnt;
    issue_cmd(3);
    tests++;
    if (o_pop_en !== 1'b1 || o_m_valid !== 1'b0) begin
      fails++;
      $display("FAIL basic_latency: got pop_en=%b valid=%b at T+1, required 1 0", o_pop_en, o_m_valid);
    end
    wait_done(20, cyc);
    tests++;
    if (cyc != 4 || o_done_cnt !== 3'd3 || o_cmd_ready !== 1'b1) begin
      fails++;
      $display("FAIL basic_done: got cycles=%0d cnt=%0d rdy=%b, required 4 3 1", cyc, o_done_cnt, o_cmd_ready);
    end
    tests++;
    if (sp != 0 || pop_cnt - pc0 != 3 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL basic_drained: got sp=%0d pops=%0d pending=%0d, required 0 3 0", sp, pop_cnt - pc0, exp_q.size());
    end
    tick();
    tests++;
    if (o_done !== 1'b0) begin
      fails++;
      $display("FAIL done_pulse_width: got o_done=%b, required 0", o_done);
    end
  endtask

  task automatic test_back_pressure();
    int pc0, p;
    clear_stack();
    push_item(8'h11); push_item(8'h22); push_item(8'h33);
    pc0 = pop_cnt;
    issue_cmd(3);
    p = 0;
    do begin
      i_m_ready = (p % 3 == 0);
      tick();
      p++;
    end while (!o_done && p < 60);
    i_m_ready = 1'b1;
    tests++;
    if (o_done !== 1'b1 || o_done_cnt !== 3'd3 || pop_cnt - pc0 != 3 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL back_pressure: got done=%b cnt=%0d pops=%0d pending=%0d, required 1 3 3 0",
               o_done, o_done_cnt, pop_cnt - pc0, exp_q.size());
    end
  endtask

  task automatic test_empty_stall();
    int pc0, cyc;
    clear_stack();
    push_item(8'hA5);
    i_m_ready = 1'b1;
    pc0 = pop_cnt;
    issue_cmd(2);
    repeat (10) tick();
    tests++;
    if (o_stall !== 1'b1 || o_pop_en !== 1'b0 || o_m_valid !== 1'b0 || pop_cnt - pc0 != 1 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL empty_stall: got stall=%b pop=%b valid=%b pops=%0d pending=%0d, required 1 0 0 1 0",
               o_stall, o_pop_en, o_m_valid, pop_cnt - pc0, exp_q.size());
    end
    exp_q.push_back({1'b1, 8'h5A});
    push_item(8'h5A);
    wait_done(10, cyc);
    tests++;
    if (o_done_cnt !== 3'd2 || sp != 0 || exp_q.size() != 0 || o_stall !== 1'b0) begin
      fails++;
      $display("FAIL stall_resume: got cnt=%0d sp=%0d pending=%0d stall=%b, required 2 0 0 0",
               o_done_cnt, sp, exp_q.size(), o_stall);
    end
  endtask

  task automatic test_zero_len();
    int pc0;
    clear_stack();
    push_item(8'h77);
    pc0 = pop_cnt;
    issue_cmd(0);
    tests++;
    if (o_done !== 1'b1 || o_done_cnt !== 3'd0 || o_cmd_ready !== 1'b1 || o_pop_en !== 1'b0) begin
      fails++;
      $display("FAIL zero_len: got done=%b cnt=%0d rdy=%b pop=%b, required 1 0 1 0",
               o_done, o_done_cnt, o_cmd_ready, o_pop_en);
    end
    tick();
    tests++;
    if (o_done !== 1'b0 || sp != 1 || pop_cnt != pc0 || o_m_valid !== 1'b0) begin
      fails++;
      $display("FAIL zero_len_after: got done=%b sp=%0d pops=%0d valid=%b, required 0 1 0 0",
               o_done, sp, pop_cnt - pc0, o_m_valid);
    end
  endtask

  task automatic test_clamp();
    int cyc;
    clear_stack();
    for (int i = 1; i <= DPT; i++) push_item(8'h40 + DW'(i));
    issue_cmd(7);
    wait_done(20, cyc);
    tests++;
    if (cyc != 5 || o_done_cnt !== 3'd4 || sp != 0 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL clamp: got cycles=%0d cnt=%0d sp=%0d pending=%0d, required 5 4 0 0",
               cyc, o_done_cnt, sp, exp_q.size());
    end
  endtask

  task automatic test_busy_reset();
    int pc0;
    clear_stack();
    push_item(8'h11); push_item(8'h22); push_item(8'h33);
    i_m_ready = 1'b1;
    pc0 = pop_cnt;
    issue_cmd(3);
    i_cmd_valid = 1'b1;
    i_cmd_len   = 3'd1;
    tests++;
    if (o_cmd_ready !== 1'b0) begin
      fails++;
      $display("FAIL busy_ready: got o_cmd_ready=%b in DRAIN, required 0", o_cmd_ready);
    end
    tick();
    tests++;
    if (o_m_valid !== 1'b1 || o_m_data !== 8'h33 || o_cmd_ready !== 1'b0) begin
      fails++;
      $display("FAIL busy_first_beat: got valid=%b data=%h rdy=%b, required 1 33 0", o_m_valid, o_m_data, o_cmd_ready);
    end
    i_cmd_valid = 1'b0;
    aresetn     = 1'b0;
    #1;
    exp_q.delete();
    tests++;
    if ({o_cmd_ready, o_m_valid, o_m_data, o_m_last, o_stall, o_done, o_done_cnt, o_pop_en}
        !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0}) begin
      fails++;
      $display("FAIL midcmd_reset: got rdy=%b v=%b d=%h l=%b st=%b dn=%b cnt=%0d pop=%b, required 1 0 00 0 0 0 0 0",
               o_cmd_ready, o_m_valid, o_m_data, o_m_last, o_stall, o_done, o_done_cnt, o_pop_en);
    end
    repeat (2) tick();
    aresetn = 1'b1;
    repeat (3) tick();
    tests++;
    if (sp != 2 || mem[1] !== 8'h22 || mem[0] !== 8'h11 || pop_cnt - pc0 != 1 || o_m_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_untouched: got sp=%0d top=%h next=%h pops=%0d valid=%b, required 2 22 11 1 0",
               sp, mem[1], mem[0], pop_cnt - pc0, o_m_valid);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_pressure();
    test_empty_stall();
    test_zero_len();
    test_clamp();
    test_busy_reset();
    tests++;
    if (pop_viol != 0) begin
      fails++;
      $display("FAIL pop_on_empty: got %0d pops while empty, required 0", pop_viol);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by 200000, required bench to finish");
    $fatal(1, "watchdog expired");
  end

endmodule
